// File: rtl/lifo_stack_pkg.sv
// Shared types and helpers for the lifo_stack slice: op decode, defaults and clog2.
package stack_pkg;

   localparam int WIDTH_D = 4;
   localparam int DEPTH_D = 4;

   typedef enum logic [2:0] {
      OP_NONE,
      OP_PUSH,
      OP_POP,
      OP_REPLACE,
      OP_CLR
   } stack_op_e;

   function automatic int clog2_f(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   // clr dominates; push with pop together means overwrite the top entry.
   function automatic stack_op_e decode_op(input logic clr, input logic push, input logic pop);
      if (clr)              return OP_CLR;
      else if (push && pop) return OP_REPLACE;
      else if (push)        return OP_PUSH;
      else if (pop)         return OP_POP;
      else                  return OP_NONE;
   endfunction

endpackage

// File: rtl/lifo_stack_if.sv
// Request/status bundle between the control FSM (master) and lifo_stack (slave).
interface lifo_stack_if
   import stack_pkg::*;
#(
   parameter int WIDTH = WIDTH_D,
   parameter int DEPTH = DEPTH_D
) ();
   localparam int CW = clog2_f(DEPTH + 1);

   // push/pop/clr are level requests taken on every rising clk edge; there is no
   // ready: a refused push or pop is reported one cycle later by the ovf/udf pulse.
   logic             push;
   logic             pop;
   logic             clr;
   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] top;
   logic [CW-1:0]    count;
   logic             empty;
   logic             full;
   logic             ovf;
   logic             udf;

   modport master (output push, pop, clr, din,
                   input  top, count, empty, full, ovf, udf);
   modport slave  (input  push, pop, clr, din,
                   output top, count, empty, full, ovf, udf);
endinterface

// File: rtl/lifo_stack_regfile.sv
// DEPTH x WIDTH storage for lifo_stack: one sync write port, one async read port.
module stack_regfile #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_all,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (clr_all) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/lifo_stack.sv
// Clocked LIFO stack owning its count and storage; optional STACK_ZERO_ON_POP_EN
// zeroes vacated entries on pop and all entries on clr.
module lifo_stack
   import stack_pkg::*;
#(
   parameter int WIDTH = WIDTH_D,
   parameter int DEPTH = DEPTH_D
) (
   input logic          clk,
   input logic          rst_n,
   lifo_stack_if.slave  s
);
   localparam int CW = clog2_f(DEPTH + 1);
   localparam int AW = clog2_f(DEPTH);

   stack_op_e        op;
   logic [CW-1:0]    count_q;
   logic             ovf_q;
   logic             udf_q;
   logic             is_empty;
   logic             is_full;
   logic             we;
   logic [AW-1:0]    waddr;
   logic [WIDTH-1:0] wdata;
   logic [AW-1:0]    top_idx;
   logic [WIDTH-1:0] rdata;
   logic             clr_all;

   assign op       = decode_op(s.clr, s.push, s.pop);
   assign is_empty = (count_q == '0);
   assign is_full  = (count_q == CW'(DEPTH));
   assign top_idx  = AW'(count_q - 1'b1);

   always_comb begin
      we    = 1'b0;
      waddr = '0;
      wdata = s.din;
      case (op)
         OP_PUSH: begin
            we    = !is_full;
            waddr = AW'(count_q);
         end
         // Replace on an empty stack degenerates to a push into slot 0.
         OP_REPLACE: begin
            we    = 1'b1;
            waddr = is_empty ? '0 : top_idx;
         end
`ifdef STACK_ZERO_ON_POP_EN
         OP_POP: begin
            we    = !is_empty;
            waddr = top_idx;
            wdata = '0;
         end
`endif
         default: ;
      endcase
   end

`ifdef STACK_ZERO_ON_POP_EN
   assign clr_all = (op == OP_CLR);
`else
   assign clr_all = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
         case (op)
            OP_CLR:     count_q <= '0;
            OP_PUSH: begin
               if (is_full) ovf_q   <= 1'b1;
               else         count_q <= count_q + 1'b1;
            end
            OP_POP: begin
               if (is_empty) udf_q   <= 1'b1;
               else          count_q <= count_q - 1'b1;
            end
            OP_REPLACE: begin
               if (is_empty) count_q <= CW'(1);
            end
            default: ;
         endcase
      end
   end

   stack_regfile #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_rf (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_all (clr_all),
      .we      (we),
      .waddr   (waddr),
      .wdata   (wdata),
      .raddr   (top_idx),
      .rdata   (rdata)
   );

   assign s.top   = is_empty ? '0 : rdata;
   assign s.count = count_q;
   assign s.empty = is_empty;
   assign s.full  = is_full;
   assign s.ovf   = ovf_q;
   assign s.udf   = udf_q;
endmodule

// File: tb/tb_lifo_stack.sv
// Directed bench for lifo_stack (WIDTH=4, DEPTH=4), hand-computed expectations.
module tb_lifo_stack;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   logic [3:0] exp_q [$];

   lifo_stack_if #(.WIDTH(4), .DEPTH(4)) bus ();

   lifo_stack #(.WIDTH(4), .DEPTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .s     (bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
      end
   endtask

   // Drive one request on the falling edge, sample 1 time unit after the rising edge.
   task automatic step(input logic p, input logic q, input logic c, input logic [3:0] d);
      @(negedge clk);
      bus.push = p;
      bus.pop  = q;
      bus.clr  = c;
      bus.din  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 4'h0);
   endtask

   task automatic check_state(input string tag, input logic [3:0] t, input logic [2:0] n,
                              input logic e, input logic f);
      check_eq({tag, "_top"},   32'(bus.top),   32'(t));
      check_eq({tag, "_count"}, 32'(bus.count), 32'(n));
      check_eq({tag, "_empty"}, 32'(bus.empty), 32'(e));
      check_eq({tag, "_full"},  32'(bus.full),  32'(f));
   endtask

   initial begin
      logic [3:0] pv [4];
      checks = 0;
      errors = 0;
      pv[0] = 4'h3; pv[1] = 4'h5; pv[2] = 4'h9; pv[3] = 4'hC;
      bus.push = 1'b0;
      bus.pop  = 1'b0;
      bus.clr  = 1'b0;
      bus.din  = 4'h0;
      rst_n    = 1'b0;
      #12;
      check_state("rst", 4'h0, 3'd0, 1'b1, 1'b0);
      check_eq("rst_ovf", 32'(bus.ovf), 32'd0);
      check_eq("rst_udf", 32'(bus.udf), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idle();
      check_state("idle", 4'h0, 3'd0, 1'b1, 1'b0);

      // fill
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0, 1'b0, pv[i]);
         exp_q.push_back(pv[i]);
         check_state($sformatf("push%0d", i), pv[i], 3'(i + 1), 1'b0, (i == 3));
      end

      // overflow pulse
      step(1'b1, 1'b0, 1'b0, 4'h7);
      check_state("ovf", 4'hC, 3'd4, 1'b0, 1'b1);
      check_eq("ovf_pulse", 32'(bus.ovf), 32'd1);
      idle();
      check_eq("ovf_drop", 32'(bus.ovf), 32'd0);

      // drain, each pop exposes the entry beneath
      for (int i = 0; i < 4; i++) begin
         check_eq($sformatf("pre_pop%0d_top", i), 32'(bus.top), 32'(exp_q[$]));
         step(1'b0, 1'b1, 1'b0, 4'h0);
         void'(exp_q.pop_back());
         check_eq($sformatf("pop%0d_top", i), 32'(bus.top),
                  (exp_q.size() == 0) ? 32'd0 : 32'(exp_q[$]));
         check_eq($sformatf("pop%0d_count", i), 32'(bus.count), 32'(3 - i));
      end
      check_eq("drained_empty", 32'(bus.empty), 32'd1);

      // underflow, back-to-back keeps the flag high
      step(1'b0, 1'b1, 1'b0, 4'h0);
      check_eq("udf_pulse", 32'(bus.udf), 32'd1);
      check_eq("udf_count", 32'(bus.count), 32'd0);
      step(1'b0, 1'b1, 1'b0, 4'h0);
      check_eq("udf_repeat", 32'(bus.udf), 32'd1);
      idle();
      check_eq("udf_drop", 32'(bus.udf), 32'd0);

      // replace
      step(1'b1, 1'b0, 1'b0, 4'h2);
      step(1'b1, 1'b1, 1'b0, 4'hE);
      check_state("repl", 4'hE, 3'd1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 4'h0);
      check_state("repl_pop", 4'h0, 3'd0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0, 4'h6);
      check_state("repl_empty", 4'h6, 3'd1, 1'b0, 1'b0);
      check_eq("repl_empty_udf", 32'(bus.udf), 32'd0);

      // replace while full: no ovf
      step(1'b1, 1'b0, 1'b0, 4'hA);
      step(1'b1, 1'b0, 1'b0, 4'hB);
      step(1'b1, 1'b0, 1'b0, 4'h1);
      step(1'b1, 1'b1, 1'b0, 4'hF);
      check_state("repl_full", 4'hF, 3'd4, 1'b0, 1'b1);
      check_eq("repl_full_ovf", 32'(bus.ovf), 32'd0);

      step(1'b0, 1'b1, 1'b0, 4'h0);
      check_state("pop_to3", 4'hB, 3'd3, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 4'h0);
      check_state("pop_to2", 4'hA, 3'd2, 1'b0, 1'b0);
`ifdef STACK_ZERO_ON_POP_EN
      check_eq("zero_on_pop_mem2", 32'(dut.u_rf.mem[2]), 32'd0);
`endif

      // clr beats push
      step(1'b1, 1'b0, 1'b0, 4'hD);
      check_state("pre_clr", 4'hD, 3'd3, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 4'h1);
      check_state("clr", 4'h0, 3'd0, 1'b1, 1'b0);
      check_eq("clr_ovf", 32'(bus.ovf), 32'd0);

      // stale contents stay unreachable after clr
      step(1'b1, 1'b0, 1'b0, 4'h8);
      step(1'b1, 1'b0, 1'b0, 4'h4);
      check_state("post_clr", 4'h4, 3'd2, 1'b0, 1'b0);

      // async reset between edges
      #2;
      rst_n = 1'b0;
      #1;
      check_state("async_rst", 4'h0, 3'd0, 1'b1, 1'b0);
      bus.push = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      idle();
      check_state("after_rst", 4'h0, 3'd0, 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
